// File: rtl/hub75_slice_scheduler.sv
// hub75_slice_scheduler
// Measures the rotor revolution period from the hall index sensor, splits it
// into ROTATIONAL_RES equal angular slices and, at every slice boundary,
// fetches that slice's column pair from the frame buffer and offers it to the
// HUB75 column driver.
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   enable_in               scheduling enable
//   index_in                hall sensor pulse (asynchronous, synchronised here)
//   fb_addr_out/fb_rd_en_out  frame-buffer slice address and one-cycle read strobe
//   fb_data_in              frame-buffer read data, valid RD_LATENCY cycles after strobe
//   column_data_out         held column pair for the HUB75 stage
//   tvalid_out/tready_in    column handshake
//   theta_out               current slice index
//   locked_out              a valid revolution period is established
//   rev_period_out          last accepted revolution period in clocks
//   overrun_count_out       slices dropped because a fetch/offer was still busy
//   fsm_state_out           scheduler state (0 idle, 1 wait, 2 fetch, 3 offer)
//
// Handshake: a column transfers on every cycle where tvalid_out && tready_in.
// Once tvalid_out rises, it and column_data_out stay constant until that
// transfer; tvalid_out drops the cycle after, and is never withdrawn early.
module hub75_slice_scheduler #(
  parameter int ROTATIONAL_RES = 1024,
  parameter int NUM_ROWS       = 64,
  parameter int RGB_RES        = 9,
  parameter int RD_LATENCY     = 2,
  parameter int PERIOD_W       = 24,
  parameter int MIN_PERIOD     = 4096
) (
  input  logic                                   clk_in,
  input  logic                                   rst_n_in,
  input  logic                                   enable_in,
  input  logic                                   index_in,
  output logic [$clog2(ROTATIONAL_RES)-1:0]      fb_addr_out,
  output logic                                   fb_rd_en_out,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  fb_data_in,
  output logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  column_data_out,
  output logic                                   tvalid_out,
  input  logic                                   tready_in,
  output logic [$clog2(ROTATIONAL_RES)-1:0]      theta_out,
  output logic                                   locked_out,
  output logic [PERIOD_W-1:0]                    rev_period_out,
  output logic [15:0]                            overrun_count_out,
  output logic [1:0]                             fsm_state_out
);

  localparam int                  TW         = $clog2(ROTATIONAL_RES);
  localparam int                  LW         = $clog2(RD_LATENCY + 1);
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [LW-1:0]       LAT_LAST   = LW'(RD_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FETCH = 2'd2,
    S_OFFER = 2'd3
  } state_t;

  state_t              state;
  logic                sync1, sync2, sync3, idx_pulse;
  logic [PERIOD_W-1:0] period_cnt;
  logic                cnt_run;
  logic [PERIOD_W-1:0] slice_len;
  logic [PERIOD_W-1:0] slice_timer;
  logic                slice_due;
  logic [LW-1:0]       lat_cnt;

  assign fsm_state_out = state;

  // Two-flop synchroniser plus registered rising-edge detect: idx_pulse is
  // high for one cycle, three clocks after the index edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      idx_pulse <= 1'b0;
    end else begin
      sync1     <= index_in;
      sync2     <= sync1;
      sync3     <= sync2;
      idx_pulse <= sync2 & ~sync3;
    end
  end

  // Period measurement and angular slice timing. The counter only runs once
  // the first index after reset has been seen, so that first pulse can never
  // produce a lock on its own.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      period_cnt     <= '0;
      cnt_run        <= 1'b0;
      rev_period_out <= '0;
      slice_len      <= '0;
      slice_timer    <= '0;
      locked_out     <= 1'b0;
      theta_out      <= '0;
      slice_due      <= 1'b0;
    end else begin
      slice_due <= 1'b0;
      if (idx_pulse) begin
        period_cnt <= {{(PERIOD_W-1){1'b0}}, 1'b1};
        cnt_run    <= 1'b1;
        if (cnt_run && period_cnt >= MIN_P && period_cnt != PERIOD_MAX) begin
          rev_period_out <= period_cnt;
          slice_len      <= period_cnt >> TW;
          slice_timer    <= period_cnt >> TW;
          locked_out     <= 1'b1;
          theta_out      <= '0;
          slice_due      <= 1'b1;
        end else begin
          locked_out <= 1'b0;
        end
      end else begin
        if (cnt_run && period_cnt != PERIOD_MAX) begin
          period_cnt <= period_cnt + 1'b1;
        end
        if (period_cnt == PERIOD_MAX) begin
          // Rotor stalled or sensor lost: the stored period is meaningless.
          locked_out <= 1'b0;
        end else if (locked_out) begin
          if (slice_timer == {{(PERIOD_W-1){1'b0}}, 1'b1}) begin
            theta_out   <= theta_out + 1'b1;
            slice_timer <= slice_len;
            slice_due   <= 1'b1;
          end else begin
            slice_timer <= slice_timer - 1'b1;
          end
        end
      end
    end
  end

  // Fetch / offer sequencer.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= S_IDLE;
      fb_addr_out       <= '0;
      fb_rd_en_out      <= 1'b0;
      column_data_out   <= '0;
      tvalid_out        <= 1'b0;
      lat_cnt           <= '0;
      overrun_count_out <= '0;
    end else begin
      fb_rd_en_out <= 1'b0;

      // A slice boundary while a column is still in flight is dropped.
      if (slice_due && (state == S_FETCH || state == S_OFFER) &&
          overrun_count_out != 16'hFFFF) begin
        overrun_count_out <= overrun_count_out + 16'd1;
      end

      case (state)
        // Idle and wait share launch logic: slice_due is issued in the same
        // cycle lock is gained, so an idle scheduler must be able to launch
        // directly or slice 0 of the first locked revolution would be lost.
        S_IDLE, S_WAIT: begin
          if (locked_out && enable_in) begin
            if (slice_due) begin
              fb_addr_out  <= theta_out;
              fb_rd_en_out <= 1'b1;
              lat_cnt      <= '0;
              state        <= S_FETCH;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        // lat_cnt is 0 in the strobe cycle; data is captured in the cycle
        // RD_LATENCY later and presented from the cycle after.
        S_FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            column_data_out <= fb_data_in;
            tvalid_out      <= 1'b1;
            state           <= S_OFFER;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_OFFER: begin
          if (tready_in) begin
            tvalid_out <= 1'b0;
            state      <= (locked_out && enable_in) ? S_WAIT : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_slice_scheduler.sv
// Directed bench for hub75_slice_scheduler with an 8-slice revolution,
// MIN_PERIOD 16, read latency 2 and a 2-row panel to keep column words short.
module tb_hub75_slice_scheduler;

  localparam int RES  = 8;
  localparam int ROWS = 2;
  localparam int RGB  = 9;
  localparam int DW   = 2 * ROWS * RGB;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          enable;
  logic                          index_sig;
  logic [2:0]                    fb_addr;
  logic                          fb_rd_en;
  logic [1:0][ROWS-1:0][RGB-1:0] fb_data;
  logic [1:0][ROWS-1:0][RGB-1:0] column;
  logic                          tvalid;
  logic                          tready;
  logic [2:0]                    theta;
  logic                          locked;
  logic [23:0]                   rev_period;
  logic [15:0]                   overrun;
  logic [1:0]                    fsm_state;

  hub75_slice_scheduler #(
    .ROTATIONAL_RES(RES),
    .NUM_ROWS(ROWS),
    .RGB_RES(RGB),
    .RD_LATENCY(2),
    .PERIOD_W(24),
    .MIN_PERIOD(16)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .enable_in(enable),
    .index_in(index_sig),
    .fb_addr_out(fb_addr),
    .fb_rd_en_out(fb_rd_en),
    .fb_data_in(fb_data),
    .column_data_out(column),
    .tvalid_out(tvalid),
    .tready_in(tready),
    .theta_out(theta),
    .locked_out(locked),
    .rev_period_out(rev_period),
    .overrun_count_out(overrun),
    .fsm_state_out(fsm_state)
  );

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;

  // Frame-buffer stand-in: data changes every cycle (cycle stamp + address),
  // so capturing in the wrong cycle gives a different word.
  int cyc = 0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    fb_data <= {cyc, 1'b0, fb_addr};
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          st_cyc[$];
  logic [2:0]  st_addr[$];
  int          rise_cyc[$];
  logic [DW-1:0] rise_col[$];
  int          fall_cyc[$];
  logic        tvalid_q = 1'b0;
  bit          idx_on = 1'b0;
  int          idx_ph = 0;
  int          idx_period = 800;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    st_cyc.delete();
    st_addr.delete();
    rise_cyc.delete();
    rise_col.delete();
    fall_cyc.delete();
  endtask

  // One clock: sample at the falling edge, log events, advance the index source.
  task automatic tick();
    @(negedge clk);
    if (fb_rd_en) begin
      st_cyc.push_back(cyc);
      st_addr.push_back(fb_addr);
    end
    if (tvalid && !tvalid_q) begin
      rise_cyc.push_back(cyc);
      rise_col.push_back(column);
    end
    if (!tvalid && tvalid_q) fall_cyc.push_back(cyc);
    tvalid_q = tvalid;
    idx_ph = (idx_ph + 1 >= idx_period) ? 0 : idx_ph + 1;
    index_sig = idx_on && (idx_ph < 4);
  endtask

  task automatic wait_strobe(input bit any_addr, input logic [2:0] a, input int bound,
                             output bit found, output logic [2:0] got);
    found = 1'b0;
    got = '0;
    for (int i = 0; i < bound && !found; i++) begin
      tick();
      if (fb_rd_en && (any_addr || fb_addr == a)) begin
        found = 1'b1;
        got = fb_addr;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit            found;
    logic [2:0]    got;
    logic [DW-1:0] col0;
    bit            stable;

    rst_n = 1'b0;
    enable = 1'b1;
    tready = 1'b1;
    index_sig = 1'b0;
    fb_data = '0;
    repeat (3) tick();

    // Reset state
    check("rst_locked", locked, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_rd_en", fb_rd_en, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_theta", theta, 0);
    check("rst_period", rev_period, 0);
    check("rst_overrun", overrun, 0);
    check("rst_column", column, 0);
    check("rst_state", fsm_state, 0);
    rst_n = 1'b1;

    // Lock on an 800-clock revolution, slice every 100 clocks
    idx_on = 1'b1;
    idx_ph = idx_period - 1;
    repeat (790) tick();
    check("first_pulse_no_lock", locked, 0);
    check("no_strobe_unlocked", st_cyc.size(), 0);
    repeat (20) tick();
    check("locked_after_2nd", locked, 1);
    check("rev_period", rev_period, 800);
    repeat (830) tick();
    check("strobe_count", st_addr.size(), 9);
    check("rise_count", rise_cyc.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < st_addr.size()) begin
        check($sformatf("strobe_addr_%0d", i), st_addr[i], i % RES);
        if (i > 0) check($sformatf("strobe_gap_%0d", i), st_cyc[i] - st_cyc[i-1], 100);
        if (i < rise_cyc.size()) begin
          check($sformatf("valid_latency_%0d", i), rise_cyc[i] - st_cyc[i], 3);
          check($sformatf("column_%0d", i), rise_col[i],
                {st_cyc[i] + 1, 1'b0, st_addr[i]});
        end
        if (i < fall_cyc.size() && i < rise_cyc.size())
          check($sformatf("handshake_len_%0d", i), fall_cyc[i] - rise_cyc[i], 1);
      end
    end
    check("overrun_zero", overrun, 0);

    // Back-pressure during slice 3 drops slice 4
    wait_strobe(1'b0, 3'd3, 900, found, got);
    check("found_slice3", found, 1);
    tready = 1'b0;
    repeat (5) tick();
    check("hold_valid", tvalid, 1);
    col0 = column;
    clear_logs();
    stable = 1'b1;
    repeat (145) begin
      tick();
      if (!tvalid || column !== col0) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("overrun_one", overrun, 1);
    check("slice4_not_fetched", st_addr.size(), 0);
    tready = 1'b1;
    wait_strobe(1'b1, 3'd0, 200, found, got);
    check("found_after_hold", found, 1);
    check("addr_after_hold", got, 5);

    // Short revolution unlocks; next full revolution relocks at theta 0
    for (int i = 0; i < 900 && idx_ph != 9; i++) tick();
    idx_ph = idx_period - 1;
    repeat (50) tick();
    check("short_unlock", locked, 0);
    clear_logs();
    repeat (700) tick();
    check("no_strobe_after_short", st_addr.size(), 0);
    repeat (60) tick();
    check("relock", locked, 1);
    check("relock_theta", theta, 0);
    check("relock_strobe_seen", st_addr.size(), 1);
    if (st_addr.size() > 0) check("relock_addr0", st_addr[0], 0);

    // Enable dropped mid-fetch: the column still goes out once
    wait_strobe(1'b0, 3'd1, 300, found, got);
    check("found_slice1", found, 1);
    tick();
    enable = 1'b0;
    clear_logs();
    repeat (300) tick();
    check("valid_after_disable", rise_cyc.size(), 1);
    check("handshake_after_disable", fall_cyc.size(), 1);
    check("idle_after_disable", fsm_state, 0);
    check("no_strobe_disabled", st_addr.size(), 0);
    check("overrun_kept", overrun, 1);
    enable = 1'b1;
    wait_strobe(1'b1, 3'd0, 150, found, got);
    check("resume_found", found, 1);
    check("resume_addr", got, 5);

    // Asynchronous reset while offering
    tready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (tvalid) found = 1'b1;
    end
    check("offer_reached", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", tvalid, 0);
    check("arst_locked", locked, 0);
    check("arst_period", rev_period, 0);
    check("arst_overrun", overrun, 0);
    check("arst_theta", theta, 0);
    check("arst_addr", fb_addr, 0);
    check("arst_column", column, 0);
    check("arst_state", fsm_state, 0);
    tick();
    rst_n = 1'b1;
    tready = 1'b1;
    idx_ph = idx_period - 1;
    repeat (400) tick();
    check("post_rst_one_pulse", locked, 0);
    repeat (410) tick();
    check("post_rst_relock", locked, 1);
    check("post_rst_period", rev_period, 800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
